// File: rtl/trace_collector.sv
// rtl/trace_collector.sv - pairs traced instructions with filter verdicts and streams kept ones as packets
//
// Purpose:
//   Holds each traced instruction for one cycle until the filter's drop
//   verdict arrives, counts dropped instructions between kept ones and
//   pushes kept instructions as {overflow, skip_count, pc, instr} packets
//   into a first-word-fall-through FIFO that drains over a valid/ready stream.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   collect_en   collection enable; the FIFO drains regardless
//   pc_valid     pc/instr valid this cycle
//   pc, instr    traced instruction
//   drop_instr   verdict for the instruction presented at the previous pc_valid
//   m_valid      packet available (head of FIFO)
//   m_ready      downstream accepts packet
//   m_data       {overflow, skip_count, pc, instr}
//   fifo_level   occupied FIFO entries
//   lost_count   saturating count of packets discarded on a full FIFO
module trace_collector #(
    parameter int FIFO_DEPTH               = 16,
    parameter int PC_WIDTH                 = 64,
    parameter int SKIP_WIDTH               = 16,
    parameter int LOST_WIDTH               = 32,
    parameter int RISC_V_INSTRUCTION_WIDTH = 32
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  collect_en,
    input  logic                                                  pc_valid,
    input  logic [PC_WIDTH-1:0]                                   pc,
    input  logic [RISC_V_INSTRUCTION_WIDTH-1:0]                   instr,
    input  logic                                                  drop_instr,
    output logic                                                  m_valid,
    input  logic                                                  m_ready,
    output logic [1+SKIP_WIDTH+PC_WIDTH+RISC_V_INSTRUCTION_WIDTH-1:0] m_data,
    output logic [$clog2(FIFO_DEPTH):0]                           fifo_level,
    output logic [LOST_WIDTH-1:0]                                 lost_count
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int DATA_W = 1 + SKIP_WIDTH + PC_WIDTH + RISC_V_INSTRUCTION_WIDTH;
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

    // Alignment stage: the verdict for an instruction arrives one cycle later.
    logic                                pend;
    logic [PC_WIDTH-1:0]                 hold_pc;
    logic [RISC_V_INSTRUCTION_WIDTH-1:0] hold_instr;

    // Packet assembly state.
    logic [SKIP_WIDTH-1:0] skip;
    logic                  ovf;

    // FIFO storage and pointers.
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       level;

    logic eval;
    logic push_req;
    logic pop;
    logic push_ok;
    logic push_rej;
    logic [SKIP_WIDTH-1:0] skip_inc;
    logic [DATA_W-1:0]     packet;

    assign eval     = pend && collect_en;
    assign push_req = eval && !drop_instr;
    assign pop      = m_valid && m_ready;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign push_ok  = push_req && ((level != FULL_LEVEL) || pop);
    assign push_rej = push_req && !push_ok;
    assign skip_inc = (skip == {SKIP_WIDTH{1'b1}}) ? skip : skip + SKIP_WIDTH'(1);
    assign packet   = {ovf, skip, hold_pc, hold_instr};

    assign m_valid    = (level != '0);
    assign m_data     = mem[rd_ptr];
    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else begin
            pend <= pc_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (pc_valid) begin
            hold_pc    <= pc;
            hold_instr <= instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skip <= '0;
            ovf  <= 1'b0;
        end else if (eval) begin
            if (drop_instr || push_rej) begin
                // A discarded packet counts as one more skipped instruction.
                skip <= skip_inc;
            end else begin
                skip <= '0;
            end
            if (push_ok) begin
                ovf <= 1'b0;
            end else if (push_rej) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lost_count <= '0;
        end else if (push_rej && (lost_count != {LOST_WIDTH{1'b1}})) begin
            lost_count <= lost_count + LOST_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= packet;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_collector.sv
// tb/tb_trace_collector.sv - directed self-checking bench for trace_collector
module tb_trace_collector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         collect_en;
    logic         pc_valid;
    logic [63:0]  pc;
    logic [31:0]  instr;
    logic         drop_instr;
    logic         m_ready;

    logic         m_valid;
    logic [112:0] m_data;
    logic [4:0]   fifo_level;
    logic [31:0]  lost_count;

    logic         m_valid4;
    logic [100:0] m_data4;
    logic [4:0]   fifo_level4;
    logic [31:0]  lost_count4;

    int checks   = 0;
    int failures = 0;

    trace_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .collect_en (collect_en),
        .pc_valid   (pc_valid),
        .pc         (pc),
        .instr      (instr),
        .drop_instr (drop_instr),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .fifo_level (fifo_level),
        .lost_count (lost_count)
    );

    trace_collector #(.SKIP_WIDTH(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .collect_en (collect_en),
        .pc_valid   (pc_valid),
        .pc         (pc),
        .instr      (instr),
        .drop_instr (drop_instr),
        .m_valid    (m_valid4),
        .m_ready    (m_ready),
        .m_data     (m_data4),
        .fifo_level (fifo_level4),
        .lost_count (lost_count4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [63:0] p);
        return {p[15:0], 16'h0013};
    endfunction

    function automatic logic [127:0] pkt(input logic ovf, input logic [15:0] skip,
                                         input logic [63:0] p);
        return {15'b0, ovf, skip, p, ins(p)};
    endfunction

    function automatic logic [127:0] pkt4(input logic ovf, input logic [3:0] skip,
                                          input logic [63:0] p);
        return {27'b0, ovf, skip, p, ins(p)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [63:0] p, input logic d);
        pc_valid   = v;
        pc         = p;
        instr      = ins(p);
        drop_instr = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; collect_en = 1'b1; m_ready = 1'b0;
        pc_valid = 1'b0; pc = '0; instr = '0; drop_instr = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_level", 128'(fifo_level), 128'(0));
        chk("rst_lost", 128'(lost_count), 128'(0));
        rst_n = 1'b1;
        cyc(0, 0, 0);

        // 1: three drops then a keep -> one packet with skip=3, 2 cycles after last pc_valid
        cyc(1, 64'h100, 0);
        cyc(1, 64'h104, 1);
        cyc(1, 64'h108, 1);
        cyc(1, 64'h10C, 1);
        chk("t1_no_valid_yet", 128'(m_valid), 128'(0));
        cyc(0, 0, 0);
        chk("t1_m_valid", 128'(m_valid), 128'(1));
        chk("t1_data", 128'(m_data), pkt(0, 3, 64'h10C));
        m_ready = 1'b1;
        cyc(0, 0, 0);
        chk("t1_drained", 128'(fifo_level), 128'(0));

        // 2: back-to-back keeps with m_ready=1 stream through at level 1
        for (int k = 0; k < 7; k++) begin
            cyc(k < 6, 64'h200 + 64'(4*k), 0);
            if (k >= 1) begin
                chk("t2_data", 128'(m_data), pkt(0, 0, 64'h200 + 64'(4*(k-1))));
                chk("t2_level", 128'(fifo_level), 128'(1));
            end
        end
        cyc(0, 0, 0);
        chk("t2_empty", 128'(m_valid), 128'(0));

        // 3: 17 keeps into a 16-deep FIFO with no drain -> one lost packet
        m_ready = 1'b0;
        for (int k = 0; k < 18; k++) cyc(k < 17, 64'h300 + 64'(4*k), 0);
        chk("t3_level_full", 128'(fifo_level), 128'(16));
        chk("t3_lost", 128'(lost_count), 128'(1));
        m_ready = 1'b1;
        for (int j = 0; j < 17; j++) begin
            if (j < 16) chk("t3_drain", 128'(m_data), pkt(0, 0, 64'h300 + 64'(4*j)));
            else        chk("t3_ovf_pkt", 128'(m_data), pkt(1, 1, 64'h400));
            cyc(j == 0, 64'h400, 0);
        end
        chk("t3_empty", 128'(fifo_level), 128'(0));

        // 4: full FIFO with simultaneous pop and push keeps level 16
        m_ready = 1'b0;
        for (int k = 0; k < 17; k++) cyc(1, 64'h500 + 64'(4*k), 0);
        chk("t4_full", 128'(fifo_level), 128'(16));
        m_ready = 1'b1;
        cyc(0, 0, 0);
        chk("t4_level_same", 128'(fifo_level), 128'(16));
        chk("t4_lost_same", 128'(lost_count), 128'(1));
        for (int j = 0; j < 16; j++) begin
            chk("t4_drain", 128'(m_data), pkt(0, 0, 64'h500 + 64'(4*(j+1))));
            cyc(0, 0, 0);
        end
        chk("t4_empty", 128'(fifo_level), 128'(0));

        // 5: 20 drops then a keep -> skip 20, or saturated 15 in the 4-bit build
        m_ready = 1'b0;
        for (int k = 0; k < 21; k++) cyc(1, 64'h800 + 64'(4*k), k >= 1);
        cyc(0, 0, 0);
        chk("t5_skip20", 128'(m_data), pkt(0, 20, 64'h850));
        chk("t5_skip_sat", 128'(m_data4), pkt4(0, 4'hF, 64'h850));
        m_ready = 1'b1;
        cyc(0, 0, 0);
        chk("t5_empty", 128'(fifo_level), 128'(0));
        chk("t5_empty4", 128'(fifo_level4), 128'(0));

        // 6: collect_en=0 ignores keeps while 2 buffered packets drain
        m_ready = 1'b0;
        cyc(1, 64'h600, 0);
        cyc(1, 64'h604, 0);
        cyc(0, 0, 0);
        chk("t6_level2", 128'(fifo_level), 128'(2));
        collect_en = 1'b0;
        m_ready = 1'b1;
        chk("t6_head0", 128'(m_data), pkt(0, 0, 64'h600));
        cyc(1, 64'h610, 0);
        chk("t6_head1", 128'(m_data), pkt(0, 0, 64'h604));
        chk("t6_level1", 128'(fifo_level), 128'(1));
        cyc(1, 64'h614, 0);
        chk("t6_level0a", 128'(fifo_level), 128'(0));
        cyc(1, 64'h618, 0);
        cyc(0, 0, 0);
        chk("t6_no_new", 128'(m_valid), 128'(0));
        collect_en = 1'b1;

        // 6b: reset mid-stream clears everything, held item is lost silently
        m_ready = 1'b0;
        cyc(1, 64'h700, 0);
        cyc(1, 64'h704, 0);
        cyc(1, 64'h708, 0);
        chk("t6_pre_level", 128'(fifo_level), 128'(2));
        rst_n = 1'b0;
        cyc(1, 64'h70C, 0);
        chk("t6_rst_valid", 128'(m_valid), 128'(0));
        chk("t6_rst_level", 128'(fifo_level), 128'(0));
        chk("t6_rst_lost", 128'(lost_count), 128'(0));
        chk("t6_rst_lost4", 128'(lost_count4), 128'(0));
        rst_n = 1'b1;
        cyc(0, 0, 0);
        chk("t6_post_level", 128'(fifo_level), 128'(0));
        chk("t6_post_valid4", 128'(m_valid4), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trace_collector.md
Name: trace_collector

Overview:
Receive-side partner of the instruction trace filter. It pairs each traced instruction (pc, instr) with the filter's drop_instr verdict, which arrives one cycle later. It counts dropped instructions between kept ones and packs each kept instruction, plus its skip count, into a packet. Packets are buffered in a first-word-fall-through FIFO and leave through a valid/ready stream to the monitoring/DMA side.

Parameters:
FIFO_DEPTH, 16, packet FIFO entries (power of two, >=2)
PC_WIDTH, 64, program counter width
SKIP_WIDTH, 16, width of the dropped-instruction counter carried in each packet
LOST_WIDTH, 32, width of the lost-packet statistics counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
collect_en  in  1  1 = collection active
pc_valid  in  1  pc/instr valid this cycle (same strobe fed to the filter)
pc  in  PC_WIDTH  program counter of the instruction
instr  in  RISC_V_INSTRUCTION_WIDTH  instruction word
drop_instr  in  1  filter verdict for the instruction presented at the previous pc_valid
m_valid  out  1  packet available
m_ready  in  1  downstream accepts packet
m_data  out  1+SKIP_WIDTH+PC_WIDTH+RISC_V_INSTRUCTION_WIDTH  {overflow, skip_count, pc, instr}, MSB first
fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
lost_count  out  LOST_WIDTH  saturating count of packets discarded on full FIFO

Behaviour:
- Reset (rst_n=0 at posedge): FIFO empty, m_valid=0, fifo_level=0, lost_count=0, skip counter=0, overflow flag=0, hold register invalid (pend=0). m_data is don't-care while m_valid=0.
- Alignment stage:
  - Cycle t, pc_valid=1: hold_pc/hold_instr <= pc/instr, pend <= 1.
  - Cycle t+1 with pend=1: drop_instr is the verdict for the held item and is evaluated this cycle.
  - pend <= pc_valid each cycle, so back-to-back pc_valid gives one evaluation per cycle.
  - pc_valid=0 with pend=1: evaluate, then pend <= 0.
- Evaluation (pend=1 and collect_en=1):
  - drop_instr=1: skip <= skip+1, saturating at all-ones. No push.
  - drop_instr=0: push {ovf, skip, hold_pc, hold_instr}.
    - Push accepted: skip <= 0, ovf <= 0.
    - Push rejected (FIFO full): packet discarded, lost_count+1 (saturating), ovf <= 1, skip <= skip+1 (saturating). The discarded instruction is treated as skipped.
- collect_en=0: evaluations are ignored (no count, no push). The FIFO still drains. The skip counter and ovf keep their values.
- FIFO:
  - First-word-fall-through: m_valid = (level != 0); m_data = head entry, stable while m_valid && !m_ready.
  - Pop when m_valid && m_ready.
  - A push is accepted when level < FIFO_DEPTH, or when level == FIFO_DEPTH and a pop occurs in the same cycle. In that case the level is unchanged.
  - Simultaneous push and pop at level 0: not possible (m_valid=0). The pushed entry appears with m_valid=1 next cycle (push-to-m_valid latency 1 cycle; total latency from pc_valid 2 cycles).
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: all state cleared next edge. Any held item and buffered packets are lost; lost_count is not incremented for them.
- All outputs are registered or derived directly from registers; no combinational path from inputs to outputs except m_ready → none (m_valid does not depend on m_ready).

Test Plan:
1. pc_valid pulses for pc=0x100..0x10C; drop_instr after each = 1,1,1,0 -> one packet {ovf=0, skip=3, pc=0x10C, instr}, m_valid 2 cycles after the 4th pc_valid.
2. pc_valid held high 6 cycles, all kept, m_ready=1 -> 6 packets in order, skip=0 each, level never exceeds 1.
3. m_ready=0, 17 kept instructions, FIFO_DEPTH=16 -> level=16, lost_count=1. Then m_ready=1 plus one more kept instruction -> 16 packets with ovf=0, then a packet with ovf=1, skip=1.
4. Level=16 with simultaneous pop and kept-instruction evaluation -> push accepted, level stays 16, lost_count unchanged.
5. SKIP_WIDTH=4, 20 dropped instructions then 1 kept -> packet skip=15 (saturated).
6. collect_en=0 during 3 kept evaluations while 2 packets are buffered -> no new packets, 2 packets drain. rst_n=0 mid-stream -> m_valid=0, level=0, lost_count=0 next cycle.
